// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared types for the calculator command front-end: opcode enum, command
// payload struct, sequencer state enum and the divide-by-zero predicate.
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int unsigned CALC_DW = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_t;

  typedef struct packed {
    calc_op_t             op;
    logic [CALC_DW-1:0]   a;
    logic [CALC_DW-1:0]   b;
  } calc_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  // Commands that must never reach the calculator.
  function automatic logic is_div_zero(input calc_cmd_t cmd);
    return (cmd.op == OP_DIV) && (cmd.b == '0);
  endfunction

endpackage

// File: rtl/calc_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// calc_cmd_sequencer_if
// Bundles the command, calculator and response buses of the sequencer.
//   cmd_*   : valid/ready command source (op, a, b)
//   calc_*  : start pulse + operands out, registered result/carry back
//   rsp_*   : valid/ready response sink (op, result, carry, err)
//   fifo_count : queued command count
// slave  = sequencer side, master = environment side.
// -----------------------------------------------------------------------------
interface calc_cmd_sequencer_if #(
  parameter int unsigned DW = 4,
  parameter int unsigned AW = 2
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;

  logic          calc_st;
  logic [1:0]    calc_op;
  logic [DW-1:0] calc_a;
  logic [DW-1:0] calc_b;
  logic [DW-1:0] calc_result;
  logic          calc_carry;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_op;
  logic [DW-1:0] rsp_result;
  logic          rsp_carry;
  logic          rsp_err;

  logic [AW:0]   fifo_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  calc_result, calc_carry,
    input  rsp_ready,
    output cmd_ready,
    output calc_st, calc_op, calc_a, calc_b,
    output rsp_valid, rsp_op, rsp_result, rsp_carry, rsp_err,
    output fifo_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output calc_result, calc_carry,
    output rsp_ready,
    input  cmd_ready,
    input  calc_st, calc_op, calc_a, calc_b,
    input  rsp_valid, rsp_op, rsp_result, rsp_carry, rsp_err,
    input  fifo_count
  );

endinterface

// File: rtl/calc_cmd_fifo.sv
// -----------------------------------------------------------------------------
// calc_cmd_fifo
// Synchronous FIFO of calc_cmd_t commands.
//   clk, rst        : clock, async active-high reset
//   push, push_data : write request (ignored when full)
//   pop, pop_data   : read request (ignored when empty); pop_data shows the head
//   full, empty     : derived from count
//   count           : entries currently stored
// -----------------------------------------------------------------------------
module calc_cmd_fifo
  import calc_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  calc_cmd_t   push_data,
  input  logic        pop,
  output calc_cmd_t   pop_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  calc_cmd_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  // Occupancy is tracked by count, so pointer equality never has to be decoded.
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];
  assign count    = count_q;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// calc_cmd_sequencer
// Command front-end for the 4-bit calculator. Queues commands, issues them one
// at a time with a single-cycle start pulse, captures the calculator result
// and returns it on a valid/ready response port, in command order.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of calc_cmd_sequencer_if (cmd_*, calc_*, rsp_*,
//              fifo_count)
// Divide-by-zero commands bypass the calculator and respond with rsp_err=1.
// -----------------------------------------------------------------------------
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter  int unsigned DW    = CALC_DW,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  calc_cmd_sequencer_if.slave  bus
);

  seq_state_t    state;
  seq_state_t    state_nxt;

  calc_cmd_t     push_data;
  calc_cmd_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop_c;
  logic [AW:0]   fifo_cnt;
  logic          ready_en_q;

  calc_cmd_t     calc_cmd_q;
  calc_cmd_t     calc_cmd_d;
  logic          calc_st_q;
  logic          calc_st_d;
  logic          rsp_valid_q;
  logic          rsp_valid_d;
  logic [1:0]    rsp_op_q;
  logic [1:0]    rsp_op_d;
  logic [DW-1:0] rsp_result_q;
  logic [DW-1:0] rsp_result_d;
  logic          rsp_carry_q;
  logic          rsp_carry_d;
  logic          rsp_err_q;
  logic          rsp_err_d;

  // Command queue
  assign push_data = '{op: calc_op_t'(bus.cmd_op), a: bus.cmd_a, b: bus.cmd_b};
  assign fifo_pop_c = (state == IDLE) & ~fifo_empty;

  calc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.cmd_valid & bus.cmd_ready),
    .push_data (push_data),
    .pop       (fifo_pop_c),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // Keeps cmd_ready low while in reset; rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en_q <= 1'b0;
    else     ready_en_q <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_nxt = is_div_zero(head) ? RESP : ISSUE;
      end
      ISSUE:   state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    calc_st_d    = 1'b0;
    calc_cmd_d   = calc_cmd_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_op_d     = rsp_op_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          calc_cmd_d = head;
          if (is_div_zero(head)) begin
            rsp_valid_d  = 1'b1;
            rsp_op_d     = head.op;
            rsp_result_d = '0;
            rsp_carry_d  = 1'b0;
            rsp_err_d    = 1'b1;
          end else begin
            calc_st_d = 1'b1;
          end
        end
      end
      CAPT: begin
        // Calculator registered its result on the edge leaving ISSUE.
        rsp_valid_d  = 1'b1;
        rsp_op_d     = calc_cmd_q.op;
        rsp_result_d = bus.calc_result;
        rsp_carry_d  = bus.calc_carry;
        rsp_err_d    = 1'b0;
      end
      RESP: begin
        if (bus.rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calc_st_q    <= 1'b0;
      calc_cmd_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      calc_st_q    <= calc_st_d;
      calc_cmd_q   <= calc_cmd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.cmd_ready  = ready_en_q & ~fifo_full;
  assign bus.calc_st    = calc_st_q;
  assign bus.calc_op    = calc_cmd_q.op;
  assign bus.calc_a     = calc_cmd_q.a;
  assign bus.calc_b     = calc_cmd_q.b;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.fifo_count = fifo_cnt;

endmodule
